// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze with timeout, multi-cycle branch flush.
// Optional stalled-cycle counter enabled by defining HAZ_STALL_CNT_EN.
module hazard_ctrl_unit #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              idex_mem_read,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_taken,
  input  logic              stall_cnt_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              pipe_hold,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_DEPTH - 1);
  localparam logic [11:0] WAIT_MAX   = 12'(MEM_TIMEOUT);

  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [11:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic        mem_wait;
  logic        load_use;

  assign mem_wait = mem_req & ~mem_ready;
  // A load into $zero never creates a dependency; during a flush the ID slot is a dead instruction.
  assign load_use = idex_mem_read & (idex_rt != '0) &
                    ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt))) &
                    (flush_cnt_q == 4'd0);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_hold   = 1'b0;
    flush_cnt_d = flush_cnt_q;
    if (mem_wait) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (flush_cnt_q != 4'd0) begin
      ifid_flush  = 1'b1;
      flush_cnt_d = flush_cnt_q - 4'd1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      flush_cnt_d = FLUSH_INIT;
    end
  end

  always_comb begin
    wait_cnt_d = 12'd0;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 12'd1;
    end
    mem_timeout_d = mem_timeout_q | (mem_wait & (wait_cnt_d == WAIT_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q   <= 4'd0;
      wait_cnt_q    <= 12'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      flush_cnt_q   <= flush_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Clear takes precedence over a stall in the same cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stall_cnt_clr;
  assign unused_stall_cnt_clr = stall_cnt_clr;
  assign stall_cnt            = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed and randomized checks of hazard_ctrl_unit against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;
  localparam int REG_AW      = 5;
  localparam int FLUSH_DEPTH = 3;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs, id_rt, idex_rt;
  logic              id_uses_rt, idex_mem_read, mem_req, mem_ready, branch_taken, stall_cnt_clr;
  logic              pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold, mem_timeout;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  int m_flush_left = 0;
  int m_streak     = 0;
  bit m_tmo        = 1'b0;
  int m_scnt       = 0;

  hazard_ctrl_unit #(
    .REG_AW(REG_AW), .FLUSH_DEPTH(FLUSH_DEPTH), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_rt(idex_rt), .idex_mem_read(idex_mem_read), .mem_req(mem_req),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .stall_cnt_clr(stall_cnt_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; idex_rt = '0;
    idex_mem_read = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    branch_taken = 1'b0; stall_cnt_clr = 1'b0;
  endtask

  // Inputs are already applied (after a falling edge); check, then advance one cycle.
  task automatic step();
    bit mw, lu, e_pcw, e_ifw, e_bub, e_fl, e_hold;
    #1;
    mw = mem_req && !mem_ready;
    lu = idex_mem_read && (idex_rt != 0) &&
         ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt))) && (m_flush_left == 0);
    e_pcw = 1; e_ifw = 1; e_bub = 0; e_fl = 0; e_hold = 0;
    if (mw) begin
      e_pcw = 0; e_ifw = 0; e_hold = 1;
    end else if (lu) begin
      e_pcw = 0; e_ifw = 0; e_bub = 1;
    end else if (m_flush_left > 0 || branch_taken) begin
      e_fl = 1;
    end
    check("pc_write", 32'(pc_write), 32'(e_pcw));
    check("ifid_write", 32'(ifid_write), 32'(e_ifw));
    check("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    check("ifid_flush", 32'(ifid_flush), 32'(e_fl));
    check("pipe_hold", 32'(pipe_hold), 32'(e_hold));
    check("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
`ifdef HAZ_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`else
    check("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    $display("cyc t=%0t rst=%0b lu=%0b mw=%0b br=%0b -> pcw=%0b bub=%0b fl=%0b hold=%0b tmo=%0b sc=%0d",
             $time, rst, lu, mw, branch_taken, pc_write, idex_bubble, ifid_flush, pipe_hold,
             mem_timeout, stall_cnt);
    @(posedge clk);
    if (rst) begin
      m_flush_left = 0; m_streak = 0; m_tmo = 0; m_scnt = 0;
    end else begin
      if (!mw && !lu) begin
        if (m_flush_left > 0) m_flush_left--;
        else if (branch_taken) m_flush_left = FLUSH_DEPTH - 1;
      end
      m_streak = mw ? m_streak + 1 : 0;
      if (m_streak >= MEM_TIMEOUT) m_tmo = 1;
      if (stall_cnt_clr) m_scnt = 0;
      else if (!e_pcw && m_scnt < (1 << CNT_W) - 1) m_scnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    // reset state with idle inputs
    #1;
    check("rst_pc_write", 32'(pc_write), 32'd1);
    check("rst_mem_timeout", 32'(mem_timeout), 32'd0);
    step();

    // load-use on rs, then the bubble clears it
    idex_mem_read = 1; idex_rt = 8; id_rs = 8;
    #1; check("lu_bubble", 32'(idex_bubble), 32'd1);
    step();
    idle(); step();
    // load into $zero
    idex_mem_read = 1; idex_rt = 0; id_rs = 0;
    #1; check("lu_zero", 32'(pc_write), 32'd1);
    step();
    // rt match but rt not a source, then rt used
    idle(); idex_mem_read = 1; idex_rt = 8; id_rt = 8; id_rs = 3; id_uses_rt = 0;
    step();
    id_uses_rt = 1; step();
    idle(); step();

    // flush with a 2-cycle wait in its second cycle
    branch_taken = 1; step();
    branch_taken = 0; mem_req = 1; step(); step();
    mem_req = 0;
    #1; check("flush_resume", 32'(ifid_flush), 32'd1);
    step(); step();
    #1; check("flush_done", 32'(ifid_flush), 32'd0);
    step();

    // branch together with load-use, then accepted next cycle
    idex_mem_read = 1; idex_rt = 9; id_rs = 9; branch_taken = 1;
    #1; check("br_lu_noflush", 32'(ifid_flush), 32'd0);
    step();
    idex_mem_read = 0; step();
    branch_taken = 0;
    // rst with two flush cycles outstanding
    rst = 1; step();
    rst = 0;
    #1;
    check("rst_flush_off", 32'(ifid_flush), 32'd0);
    check("rst_pcw_on", 32'(pc_write), 32'd1);
    step();

    // stall counter: 3 load-use + 5 wait cycles
    stall_cnt_clr = 1; step(); idle();
    for (int i = 0; i < 3; i++) begin
      idex_mem_read = 1; idex_rt = 5; id_rs = 5; step();
      idle(); step();
    end
    mem_req = 1;
    for (int i = 0; i < 5; i++) step();
    idle();
    #1;
`ifdef HAZ_STALL_CNT_EN
    check("stall_cnt8", 32'(stall_cnt), 32'd8);
`endif
    stall_cnt_clr = 1; mem_req = 1; step();
    idle(); step();
    rst = 1; step(); rst = 0;

    // timeout after the 4th consecutive wait; sticky afterwards
    mem_req = 1;
    for (int i = 0; i < 6; i++) step();
    mem_req = 0; step(); step();
    #1; check("tmo_sticky", 32'(mem_timeout), 32'd1);
    rst = 1; step(); rst = 0;
    #1; check("tmo_cleared", 32'(mem_timeout), 32'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst           = ($urandom_range(0, 79) == 0);
      id_rs         = REG_AW'($urandom_range(0, 3));
      id_rt         = REG_AW'($urandom_range(0, 3));
      idex_rt       = REG_AW'($urandom_range(0, 3));
      id_uses_rt    = $urandom_range(0, 1) == 1;
      idex_mem_read = $urandom_range(0, 2) == 0;
      mem_req       = $urandom_range(0, 2) == 0;
      mem_ready     = $urandom_range(0, 2) == 0;
      branch_taken  = $urandom_range(0, 3) == 0;
      stall_cnt_clr = $urandom_range(0, 31) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the five-stage MIPS core, replacing the single-cycle load-use detector. Sits beside the ID stage and drives PC, IF/ID and ID/EX control. It handles load-use stalls with `$zero` masking and optional-rt qualification, and freezes the pipeline on a multi-cycle data-memory handshake with a timeout monitor. It also generates a multi-cycle IF/ID flush after taken branches/jumps.

## Interface
Parameters:
- REG_AW, 5, register-address width
- FLUSH_DEPTH, 1, IF/ID flush cycles per taken branch (1..15)
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before timeout flag (1..2^12-1)
- CNT_W, 16, stall-counter width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_rs  in  REG_AW  rs of instruction in ID
- id_rt  in  REG_AW  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- idex_rt  in  REG_AW  destination rt of instruction in EX
- idex_mem_read  in  1  EX instruction is a load
- mem_req  in  1  MEM stage issues a data-memory access this cycle
- mem_ready  in  1  data memory completes access this cycle
- branch_taken  in  1  ID resolved a taken branch/jump
- stall_cnt_clr  in  1  clear stall counter (macro builds only)
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- idex_bubble  out  1  zero ID/EX control fields
- ifid_flush  out  1  clear IF/ID to NOP
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- mem_timeout  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  stalled-cycle count (macro builds only)

## Operation
- mem_wait = mem_req & ~mem_ready. load_use = idex_mem_read & (idex_rt != 0) & ((idex_rt == id_rs) | (id_uses_rt & idex_rt == id_rt)) & (flush_cnt == 0).
- Priority: mem_wait > load_use > flush > run.
- mem_wait: pc_write=0, ifid_write=0, pipe_hold=1, idex_bubble=0, ifid_flush=0; flush_cnt frozen; branch_taken ignored.
- load_use (no mem_wait): pc_write=0, ifid_write=0, idex_bubble=1, pipe_hold=0, ifid_flush=0; branch_taken ignored (branch re-resolved next cycle).
- Flush: accepted when branch_taken & flush_cnt==0 & no stall → ifid_flush=1 that cycle, flush_cnt ← FLUSH_DEPTH-1. While flush_cnt>0 and no mem_wait: ifid_flush=1, decrement. branch_taken while flush_cnt>0 ignored.
- Run: pc_write=1, ifid_write=1, others 0.
- State: flush_cnt (4 b), wait_cnt (12 b), mem_timeout, stall_cnt. Outputs other than mem_timeout and stall_cnt are combinational from inputs and state.
- wait_cnt: increments each mem_wait cycle, saturating at MEM_TIMEOUT; cleared on any non-wait cycle. mem_timeout ← 1 when wait_cnt reaches MEM_TIMEOUT; held until rst. Stalling continues regardless.

## Timing
- Reset (rst=1 at edge): flush_cnt=0, wait_cnt=0, mem_timeout=0, stall_cnt=0. With all inputs low, outputs are pc_write=1, ifid_write=1, all others 0.
- Load-use: exactly one bubble per load; the next cycle sees the NOP in EX, so load_use drops.
- Flush: ifid_flush high for FLUSH_DEPTH non-wait cycles, starting in the branch cycle. mem_wait mid-flush extends the window without losing counts.
- rst mid-flush or mid-wait: counters clear at that edge, and run-state outputs apply the next cycle.
- mem_timeout rises on the edge where the MEM_TIMEOUT-th consecutive wait cycle completes.

## Configuration
- HAZ_STALL_CNT_EN defined: stall_cnt counts cycles with pc_write=0, saturating at 2^CNT_W-1. stall_cnt_clr zeroes it on the next edge; clear wins over increment.
- Not defined: counter logic is removed, stall_cnt is tied to 0, and stall_cnt_clr is unused.

## Test plan
- idex_mem_read=1, idex_rt=8, id_rs=8 → pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. Repeat with idex_rt=0 → no stall. Repeat with id_rt=8, id_uses_rt=0 → no stall.
- FLUSH_DEPTH=3, branch_taken pulse → ifid_flush=1 for 3 cycles. Insert a 2-cycle mem_wait in the second cycle → flush spans 5 cycles with ifid_flush=0 during the wait.
- branch_taken with load_use in the same cycle → no flush and bubble=1. Next cycle branch_taken=1 → flush accepted.
- MEM_TIMEOUT=4, mem_req=1, mem_ready=0 for 6 cycles → pipe_hold=1 throughout and mem_timeout rises after cycle 4. Drop mem_req → mem_timeout stays 1 until rst.
- rst asserted mid-flush with flush_cnt=2 → next cycle ifid_flush=0, pc_write=1.
- HAZ_STALL_CNT_EN, 3 load-use + 5 wait cycles → stall_cnt=8. Assert stall_cnt_clr together with a stall → stall_cnt=0.
